instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_1000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning fetch-buffer entries; legal values 2..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address to instruction memory; combinational copy of fetch_pc.
REQ-006 SHALL have port imem_rdata, input, 32 bits: instruction word, valid in the same cycle as imem_addr (combinational memory).
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: redirect target byte address.
REQ-009 SHALL have port out_valid, output, 1 bit: buffer head holds a valid instruction.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-011 SHALL have port out_instr, output, 32 bits: head instruction word.
REQ-012 SHALL have port out_pc, output, 32 bits: byte address of the head instruction.
REQ-013 SHALL have port out_pc_plus4, output, 32 bits: out_pc + 4, modulo 2^32.
REQ-014 SHALL have port fetch_error, output, 1 bit: sticky misaligned-redirect flag.

Function
REQ-015 SHALL implement state machine RUN/HALT; reset -> RUN; RUN -> HALT on accepted redirect with redirect_pc[1:0] != 0; HALT exits only on reset.
REQ-016 SHALL keep fetch_pc register; imem_addr = fetch_pc in every state.
REQ-017 SHALL enqueue {imem_rdata, fetch_pc} and advance fetch_pc by 4 when state=RUN, redirect_valid=0, and space exists.
REQ-018 Space SHALL exist when count < DEPTH, or count = DEPTH and the head is dequeued in the same cycle.
REQ-019 Dequeue SHALL occur when out_valid=1 and out_ready=1; simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-020 Latency SHALL be one cycle: a word enqueued at edge N is visible at out_* after edge N when the buffer was empty.
REQ-021 Buffer SHALL be FIFO ordered; out_instr/out_pc SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Aligned redirect SHALL take priority over enqueue/dequeue: flush all entries (count=0), fetch_pc <= redirect_pc, no enqueue that cycle; out_valid=0 the next cycle.
REQ-023 Misaligned redirect SHALL flush the buffer, leave fetch_pc unchanged, set fetch_error=1, and enter HALT.
REQ-024 In HALT no enqueue SHALL occur and redirect_valid SHALL be ignored; entries already buffered SHALL still drain via out_ready, but a misaligned redirect flush leaves none.
REQ-025 fetch_pc SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error.
REQ-026 A redirect arriving while out_valid=1 and out_ready=1 SHALL flush the head: it SHALL be counted as dequeued and discarded, not delivered twice.

Reset
REQ-027 On reset: state=RUN, fetch_pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=4, fetch_error=0.
REQ-028 Reset asserted mid-operation SHALL override redirect, enqueue and dequeue in that cycle and discard all buffered entries.
REQ-029 imem_addr SHALL equal RESET_PC in the first cycle after reset deasserts.

Verification
REQ-030 Reset release, memory 0x1000=FFC4A303, 0x1004=0064A423, out_ready=1 -> out_instr FFC4A303/pc 1000 one cycle later, then 0064A423/pc 1004, one per cycle.
REQ-031 out_ready=0 for 5 cycles, DEPTH=2 -> count saturates at 2, imem_addr stops at 0x1008, head stays pc 0x1000; out_ready=1 resumes in order 1000, 1004, 1008.
REQ-032 Full buffer, redirect_valid=1, redirect_pc=0x100C -> next cycle out_valid=0, imem_addr=0x100C; following cycle out_pc=0x100C, out_instr=FE420AE3.
REQ-033 redirect_pc=0x1002 -> fetch_error=1 next cycle and stays 1, out_valid=0, imem_addr frozen; later aligned redirects ignored; reset clears to pc 0x1000.
REQ-034 redirect_pc=0xFFFF_FFFC, out_ready=1 -> out_pc sequence FFFFFFFC, 00000000, 00000004; out_pc_plus4 of first = 0; fetch_error stays 0.
REQ-035 reset asserted with 2 valid entries and redirect_valid=1 -> next cycle count=0, out_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch unit with in-order fetch buffer and redirect handling
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fetch_error
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];

    logic deq;
    logic enq;
    logic space;
    logic redirect_take;
    logic redirect_ok;
    logic redirect_bad;

    // Ring pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Handshake decode: a redirect seen in RUN preempts enqueue; in HALT redirects are ignored.
    always_comb begin
        out_valid     = (count != '0);
        deq           = out_valid && out_ready;
        redirect_take = (state == RUN) && redirect_valid;
        redirect_ok   = redirect_take && (redirect_pc[1:0] == 2'b00);
        redirect_bad  = redirect_take && (redirect_pc[1:0] != 2'b00);
        space         = (count < FULL) || deq;
        enq           = (state == RUN) && !redirect_valid && space;
    end

    // Head entry is presented when valid; empty buffer shows zero so out_pc_plus4 reads 4.
    always_comb begin
        imem_addr    = fetch_pc;
        out_instr    = out_valid ? buf_instr[head] : 32'h0;
        out_pc       = out_valid ? buf_pc[head] : 32'h0;
        out_pc_plus4 = out_pc + 32'd4;
    end

    // Next-state logic: a misaligned redirect is the only way into HALT, and only reset leaves it.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (redirect_bad) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Fetch PC, buffer pointers, occupancy and sticky error; redirect flushes everything at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            fetch_error <= 1'b0;
        end else if (redirect_take) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            if (redirect_ok) fetch_pc    <= redirect_pc;
            else             fetch_error <= 1'b1;
        end else begin
            if (enq) begin
                tail     <= ptr_next(tail);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (deq) head <= ptr_next(head);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && !redirect_take && enq) begin
            buf_instr[tail] <= imem_rdata;
            buf_pc[tail]    <= fetch_pc;
        end
    end

endmodule
